// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;
    localparam int ICACHE_ADDR_WIDTH  = 32;
    localparam int ICACHE_INST_WIDTH  = 32;
    localparam int ICACHE_INDEX_WIDTH = 7;
    localparam int BEAT_WIDTH         = 2;
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_e;
endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = cache side, master = fetch stage plus memory controller.
interface icache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  if_icache_en_in;
    logic [ADDR_WIDTH-1:0] if_icache_inst_addr_in;
    logic                  rob_icache_flush_in;
    logic                  icache_if_rdy_out;
    logic                  icache_if_miss_out;
    logic                  icache_if_valid_out;
    logic [INST_WIDTH-1:0] icache_if_inst_out;
    logic [ADDR_WIDTH-1:0] icache_if_pc_out;
    logic                  icache_mem_en_out;
    logic [ADDR_WIDTH-1:0] icache_mem_addr_out;
    logic                  mem_icache_valid_in;
    logic [7:0]            mem_icache_data_in;

    modport slave (
        input  if_icache_en_in, if_icache_inst_addr_in, rob_icache_flush_in,
               mem_icache_valid_in, mem_icache_data_in,
        output icache_if_rdy_out, icache_if_miss_out, icache_if_valid_out,
               icache_if_inst_out, icache_if_pc_out, icache_mem_en_out, icache_mem_addr_out
    );

    modport master (
        output if_icache_en_in, if_icache_inst_addr_in, rob_icache_flush_in,
               mem_icache_valid_in, mem_icache_data_in,
        input  icache_if_rdy_out, icache_if_miss_out, icache_if_valid_out,
               icache_if_inst_out, icache_if_pc_out, icache_mem_en_out, icache_mem_addr_out
    );
endinterface

// File: rtl/icache_line_array.sv
// Tag/data/valid storage: combinational read by index, synchronous write,
// valid bits cleared asynchronously on reset (tag/data need no reset).
module icache_line_array #(
    parameter int INDEX_WIDTH = 7,
    parameter int TAG_WIDTH   = 23,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [DATA_WIDTH-1:0]  wr_data
);
    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];

    // Set the valid bit of the line being written
    always_comb begin
        valid_d = valid_q;
        if (wr_en) valid_d[wr_idx] = 1'b1;
    end

    // Valid bits: reset invalidates every line
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Tag/data storage, written once per completed fill
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, filled by four
// byte reads. Optional hit/miss counters under `ICACHE_PERF_CNT_EN.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
    parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH,
    parameter int INST_WIDTH  = ICACHE_INST_WIDTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    icache_if.slave     bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] icache_hit_cnt_out,
    output logic [31:0] icache_miss_cnt_out
`endif
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

    icache_state_e         state_q, state_d;
    logic [BEAT_WIDTH-1:0] k_q, k_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INST_WIDTH-1:0] fill_q, fill_d;
    logic                  rdy_q, rdy_d, miss_q, miss_d, valid_q, valid_d, mem_en_q, mem_en_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;

    logic [ADDR_WIDTH-1:0] req_base;
    logic                  rd_valid, lookup_hit, accept, wr_en;
    logic [TAG_WIDTH-1:0]  rd_tag;
    logic [INST_WIDTH-1:0] rd_data;

    // Word-aligned request address; the low two bits never matter
    assign req_base   = bus.if_icache_inst_addr_in & ~ADDR_WIDTH'(3);
    assign lookup_hit = rd_valid && (rd_tag == req_base[ADDR_WIDTH-1:INDEX_WIDTH+2]);
    // A flush in the same cycle drops the request outright
    assign accept     = (state_q == IDLE) && rdy_q && rdy_in &&
                        bus.if_icache_en_in && !bus.rob_icache_flush_in;

    icache_line_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH),
        .DATA_WIDTH  (INST_WIDTH)
    ) u_lines (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd_idx   (req_base[INDEX_WIDTH+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (addr_q[INDEX_WIDTH+1:2]),
        .wr_tag   (addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2]),
        .wr_data  (fill_d)
    );

    // Next-state: lookup in IDLE, byte assembly and line write in FILL
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        addr_d     = addr_q;
        fill_d     = fill_q;
        rdy_d      = rdy_q;
        miss_d     = miss_q;
        valid_d    = 1'b0;
        inst_d     = inst_q;
        pc_d       = pc_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lookup_hit) begin
                        valid_d = 1'b1;
                        inst_d  = rd_data;
                        pc_d    = req_base;
                    end else begin
                        state_d    = FILL;
                        k_d        = '0;
                        addr_d     = req_base;
                        rdy_d      = 1'b0;
                        miss_d     = 1'b1;
                        mem_en_d   = 1'b1;
                        mem_addr_d = req_base;
                    end
                end
            end
            FILL: begin
                if (bus.rob_icache_flush_in) begin
                    // Abandon the fill; the partial line is never written
                    state_d  = IDLE;
                    k_d      = '0;
                    rdy_d    = 1'b1;
                    miss_d   = 1'b0;
                    mem_en_d = 1'b0;
                end else if (bus.mem_icache_valid_in) begin
                    fill_d[{k_q, 3'b000} +: 8] = bus.mem_icache_data_in;
                    if (k_q == LAST_BEAT) begin
                        wr_en    = rdy_in;
                        state_d  = IDLE;
                        k_d      = '0;
                        rdy_d    = 1'b1;
                        miss_d   = 1'b0;
                        mem_en_d = 1'b0;
                        valid_d  = 1'b1;
                        inst_d   = fill_d;
                        pc_d     = addr_q;
                    end else begin
                        k_d        = k_q + 2'd1;
                        mem_addr_d = addr_q | ADDR_WIDTH'(k_d);
                    end
                end
            end
            default: ;
        endcase
    end

    // State and response registers; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            k_q        <= '0;
            addr_q     <= '0;
            fill_q     <= '0;
            rdy_q      <= 1'b1;
            miss_q     <= 1'b0;
            valid_q    <= 1'b0;
            inst_q     <= '0;
            pc_q       <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            fill_q     <= fill_d;
            rdy_q      <= rdy_d;
            miss_q     <= miss_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.icache_if_rdy_out   = rdy_q;
    assign bus.icache_if_miss_out  = miss_q;
    assign bus.icache_if_valid_out = valid_q;
    assign bus.icache_if_inst_out  = inst_q;
    assign bus.icache_if_pc_out    = pc_q;
    assign bus.icache_mem_en_out   = mem_en_q;
    assign bus.icache_mem_addr_out = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Count serviced lookups; flush never clears the counts
    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, accept && lookup_hit};
        miss_cnt_d = miss_cnt_q + {31'd0, accept && !lookup_hit};
    end

    // Counter registers, wrapping naturally at 2^32
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_in) begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign icache_hit_cnt_out  = hit_cnt_q;
    assign icache_miss_cnt_out = miss_cnt_q;
`endif
endmodule
